// File: rtl/ecg_group_scheduler_if.sv
// ecg_group_scheduler_if: encoder/packer handshake bundle for the ECG group scheduler
interface ecg_group_scheduler_if;
  logic       start;
  logic [2:0] comp_skip_in;
  logic       enc_valid_op;
  logic [6:0] enc_size;
  logic       out_ready;
  logic [1:0] ecgidx;
  logic [1:0] component_idx;
  logic       component_skip;
  logic       enc_strobe;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       err_oversize;
  logic [9:0] bit_count;
  modport master (
    input  start, comp_skip_in, enc_valid_op, enc_size, out_ready,
    output ecgidx, component_idx, component_skip, enc_strobe, out_valid,
           busy, done, err_oversize, bit_count
  );
  modport slave (
    output start, comp_skip_in, enc_valid_op, enc_size, out_ready,
    input  ecgidx, component_idx, component_skip, enc_strobe, out_valid,
           busy, done, err_oversize, bit_count
  );
endinterface

// File: rtl/ecg_group_scheduler.sv
// ecg_group_scheduler: sequences 12 ECG groups through the encoder; ECG_SCHED_BITCOUNT_EN adds a saturating bit_count
module ecg_group_scheduler (
  input logic clk,
  input logic rst,
  ecg_group_scheduler_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] ecg_r, comp_r;
  logic [3:0] skip_r;
  logic err_r, adv, last;
  assign last = comp_r == 2'd2 && ecg_r == 2'd3;
  always_comb begin
    state_nxt = state;
    adv = 1'b0;
    unique case (state)
      IDLE:    state_nxt = bus.start ? ISSUE : IDLE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt = bus.enc_valid_op ? HOLD : CAPTURE;
        adv = !bus.enc_valid_op;
      end
      HOLD:    adv = bus.out_ready;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (adv) state_nxt = last ? DONE : ISSUE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ecg_r  <= '0;
      comp_r <= '0;
      skip_r <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        skip_r <= {1'b0, bus.comp_skip_in};
        err_r  <= 1'b0;
      end
      if (state == CAPTURE && !bus.enc_valid_op) err_r <= 1'b1;
      if (adv) begin
        ecg_r  <= ecg_r + 2'd1;
        comp_r <= last ? 2'd0 : comp_r + {1'b0, ecg_r == 2'd3};
      end
    end
  end
  assign bus.ecgidx         = ecg_r;
  assign bus.component_idx  = comp_r;
  assign bus.component_skip = state != IDLE && skip_r[comp_r];
  assign bus.enc_strobe     = state == ISSUE;
  assign bus.out_valid      = state == HOLD;
  assign bus.busy           = state != IDLE;
  assign bus.done           = state == DONE;
  assign bus.err_oversize   = err_r;
`ifdef ECG_SCHED_BITCOUNT_EN
  logic [6:0]  size_r;
  logic [9:0]  cnt_r;
  logic [10:0] sum;
  assign sum = {1'b0, cnt_r} + {4'd0, size_r};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (state == IDLE && bus.start) cnt_r <= '0;
      if (state == CAPTURE) size_r <= bus.enc_size;
      if (state == HOLD && bus.out_ready) cnt_r <= sum[10] ? 10'h3ff : sum[9:0];
    end
  end
  assign bus.bit_count = cnt_r;
`else
  assign bus.bit_count = '0;
`endif
endmodule

// File: doc/ecg_group_scheduler.md
ECG_GROUP_SCHEDULER -- requirements
Module: ecg_group_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, 1-cycle request to encode one block of 12 ECGs.
REQ-004 SHALL have port comp_skip_in, input, 3, per-component skip: bit c applies to component c.
REQ-005 SHALL have port enc_valid_op, input, 1, encoder valid_op, sampled one cycle after issue.
REQ-006 SHALL have port enc_size, input, 7, encoder sizeof_encoded_ECG, sampled with enc_valid_op.
REQ-007 SHALL have port out_ready, input, 1, downstream packer accepts the current group.
REQ-008 SHALL have port ecgidx, output, 2, ECG index driven to the encoder.
REQ-009 SHALL have port component_idx, output, 2, component driven to the encoder (0 luma, 1 Co, 2 Cg).
REQ-010 SHALL have port component_skip, output, 1, comp_skip_in bit for the current component_idx.
REQ-011 SHALL have port enc_strobe, output, 1, sample-fetch strobe: samples for (component_idx, ecgidx) are presented this cycle.
REQ-012 SHALL have port out_valid, output, 1, encoder output is held for the packer.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, 1-cycle pulse at block end.
REQ-015 SHALL have port err_oversize, output, 1, sticky flag: at least one group had enc_valid_op=0.
REQ-016 SHALL have port bit_count, output, 10, accumulated encoded bits for the block.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, CAPTURE, HOLD and DONE.
REQ-018 SHALL move from IDLE to ISSUE on start=1, latching comp_skip_in and clearing err_oversize and bit_count.
REQ-019 SHALL ignore start in any state other than IDLE.
REQ-020 SHALL issue groups in component-major order, component_idx 0..2 outer and ecgidx 0..3 inner, for 12 groups total.
REQ-021 SHALL assert enc_strobe only in ISSUE, for exactly one cycle per group, then go to CAPTURE.
REQ-022 SHALL sample enc_valid_op/enc_size in CAPTURE, one cycle after ISSUE, matching the encoder's registered latency.
REQ-023 SHALL, in CAPTURE with enc_valid_op=1, go to HOLD and assert out_valid.
REQ-024 SHALL, in CAPTURE with enc_valid_op=0, set err_oversize, not assert out_valid for that group, add 0 to bit_count, and advance.
REQ-025 SHALL hold out_valid, ecgidx and component_idx stable in HOLD until out_ready=1.
REQ-026 SHALL treat out_valid and out_ready high in the same cycle as accepted and advance the next cycle.
REQ-027 SHALL, on advance with ecgidx=3, wrap ecgidx to 0 and increment component_idx.
REQ-028 SHALL, after component_idx=2 / ecgidx=3, go to DONE; DONE pulses done and returns to IDLE.
REQ-029 SHALL still issue skipped components (component_skip=1) through the same ISSUE/CAPTURE/HOLD sequence.
REQ-030 SHALL keep ecgidx, component_idx and component_skip at 0 in IDLE.
REQ-031 SHALL give a minimum latency of 3 cycles per group with out_ready held high, i.e. 37 cycles from start to done.

Reset
REQ-032 SHALL, on rst low, immediately force state IDLE with all outputs 0, including err_oversize and bit_count.
REQ-033 SHALL, on reset mid-block, abandon the block with no done pulse and resume only on a new start.

Configuration
REQ-034 SHALL compile in, when macro ECG_SCHED_BITCOUNT_EN is defined, a saturating (1023) accumulator that adds enc_size to bit_count on each accepted group.
REQ-035 SHALL, without ECG_SCHED_BITCOUNT_EN, tie bit_count to constant 0 and synthesize no accumulator, with all other behaviour identical.

Verification
REQ-036 SHALL verify: start, out_ready=1, enc_valid_op=1, enc_size=20 on every group -> 12 out_valid pulses in order (0,0)..(2,3), done at cycle 37, bit_count=240 (macro on) or 0 (macro off).
REQ-037 SHALL verify: out_ready held 0 for 5 cycles at group (1,2) -> out_valid and indices stable for 5 cycles, then advance to (1,3).
REQ-038 SHALL verify: enc_valid_op=0 on group (0,1) -> err_oversize=1 until the next start, 11 out_valid pulses, done still asserted.
REQ-039 SHALL verify: comp_skip_in=3'b010 -> component_skip=1 only while component_idx=1.
REQ-040 SHALL verify: rst low at group (2,0) -> all outputs 0 the same cycle, no done pulse; start pulsed during busy -> ignored.
